// File: rtl/pio_pkg.sv
// Shared widths, state encoding and the sequential next-PC helper
// for the PIO program-counter sequencer.
package pio_pkg;

    localparam int unsigned PC_W    = 5;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned DELAY_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        DELAY = 2'd2
    } state_e;

    // Sequential advance: jump back to the window bottom at the window top,
    // otherwise increment with natural modulo-32 rollover.
    function automatic logic [PC_W-1:0] seq_next_pc(
        input logic [PC_W-1:0] cur,
        input logic [PC_W-1:0] bottom,
        input logic [PC_W-1:0] top
    );
        logic [PC_W-1:0] nxt;
        if (cur == top) begin
            nxt = bottom;
        end else begin
            nxt = cur + PC_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pio_pc_sequencer.sv
// PIO program-counter sequencer: walks a wrap window of a 32-entry
// instruction store, handling stalls, jumps and post-instruction delays.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   sm_en               enable; low freezes all sequencing state
//   restart             pulse; reload pc to wrap_bottom and enter EXEC
//   wrap_bottom/top     wrap window bounds
//   stall               executor cannot retire this cycle
//   jmp_valid/jmp_addr  jump request and target for the current instruction
//   delay               post-instruction delay cycles
//   read_addr           register-file read address (equals pc)
//   instr_in            combinational register-file read data
//   instr_valid         instr_out carries an instruction this cycle
//   instr_out           instr_in when valid, else zero
//   pc                  current program counter
module pio_pc_sequencer
    import pio_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sm_en,
    input  logic               restart,
    input  logic [PC_W-1:0]    wrap_bottom,
    input  logic [PC_W-1:0]    wrap_top,
    input  logic               stall,
    input  logic               jmp_valid,
    input  logic [PC_W-1:0]    jmp_addr,
    input  logic [DELAY_W-1:0] delay,
    output logic [PC_W-1:0]    read_addr,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-PC selection: restart > !sm_en > stall > jump > advance
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (restart) begin
            state_d = EXEC;
            pc_d    = wrap_bottom;
            cnt_d   = '0;
        end else if (sm_en) begin
            case (state_q)
                IDLE: begin
                    state_d = EXEC;
                end
                EXEC: begin
                    if (!stall) begin
                        pc_d = jmp_valid ? jmp_addr
                                         : seq_next_pc(pc_q, wrap_bottom, wrap_top);
                        if (delay != '0) begin
                            cnt_d   = delay;
                            state_d = DELAY;
                        end
                    end
                end
                DELAY: begin
                    // Counter value 1 marks the last non-valid cycle.
                    if (cnt_q <= DELAY_W'(1)) begin
                        cnt_d   = '0;
                        state_d = EXEC;
                    end else begin
                        cnt_d = cnt_q - DELAY_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs: zero-latency fetch straight from the register-file read port
    always_comb begin
        instr_valid = 1'b0;
        instr_out   = '0;
        read_addr   = pc_q;
        pc          = pc_q;
        if ((state_q == EXEC) && sm_en) begin
            instr_valid = 1'b1;
            instr_out   = instr_in;
        end
    end

endmodule

// File: tb/tb_pio_pc_sequencer.sv
// Bench for pio_pc_sequencer: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model.
module tb_pio_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sm_en;
    logic        restart;
    logic [4:0]  wrap_bottom;
    logic [4:0]  wrap_top;
    logic        stall;
    logic        jmp_valid;
    logic [4:0]  jmp_addr;
    logic [4:0]  delay;
    logic [4:0]  read_addr;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [4:0]  pc;

    logic [15:0] mem [32];
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign instr_in = mem[read_addr];

    pio_pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sm_en       (sm_en),
        .restart     (restart),
        .wrap_bottom (wrap_bottom),
        .wrap_top    (wrap_top),
        .stall       (stall),
        .jmp_valid   (jmp_valid),
        .jmp_addr    (jmp_addr),
        .delay       (delay),
        .read_addr   (read_addr),
        .instr_in    (instr_in),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .pc          (pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart(input logic [4:0] bottom, input logic [4:0] top);
        wrap_bottom = bottom;
        wrap_top    = top;
        sm_en       = 1'b1;
        stall       = 1'b0;
        jmp_valid   = 1'b0;
        jmp_addr    = 5'd0;
        delay       = 5'd0;
        restart     = 1'b1;
        #1;
        tick();
        restart = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sm_en = 1'b1; restart = 1'b0; stall = 1'b0;
        jmp_valid = 1'b0; jmp_addr = 5'd0; delay = 5'd0;
        wrap_bottom = 5'd0; wrap_top = 5'd3;
        #3;
        total_cnt++;
        if (pc !== 5'd0 || read_addr !== 5'd0) $display("FAIL reset_pc got=%0d/%0d exp=0", pc, read_addr);
        else pass_cnt++;
        total_cnt++;
        if (instr_valid !== 1'b0 || instr_out !== 16'h0000)
            $display("FAIL reset_out got valid=%0b out=%h exp valid=0 out=0000", instr_valid, instr_out);
        else pass_cnt++;
        tick();
        tick();
    endtask

    task automatic test_wrap_basic();
        int exp_pc [6] = '{0, 1, 2, 3, 0, 1};
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (instr_valid !== 1'b0 || pc !== 5'd0)
            $display("FAIL idle_first got valid=%0b pc=%0d exp valid=0 pc=0", instr_valid, pc);
        else pass_cnt++;
        tick();
        for (int i = 0; i < 6; i++) begin
            #1;
            total_cnt++;
            if (pc !== 5'(exp_pc[i]) || instr_valid !== 1'b1 || instr_out !== mem[exp_pc[i]])
                $display("FAIL wrap_basic[%0d] got pc=%0d valid=%0b out=%h exp pc=%0d valid=1 out=%h",
                         i, pc, instr_valid, instr_out, exp_pc[i], mem[exp_pc[i]]);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_modulo_wrap();
        int exp_pc [5] = '{30, 31, 0, 1, 30};
        do_restart(5'd30, 5'd1);
        for (int i = 0; i < 5; i++) begin
            #1;
            total_cnt++;
            if (pc !== 5'(exp_pc[i]) || instr_valid !== 1'b1)
                $display("FAIL modulo_wrap[%0d] got pc=%0d valid=%0b exp pc=%0d valid=1",
                         i, pc, instr_valid, exp_pc[i]);
            else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_jump_delay();
        do_restart(5'd5, 5'd20);
        jmp_valid = 1'b1; jmp_addr = 5'd12; delay = 5'd3;
        #1;
        total_cnt++;
        if (pc !== 5'd5 || instr_valid !== 1'b1)
            $display("FAIL jump_src got pc=%0d valid=%0b exp pc=5 valid=1", pc, instr_valid);
        else pass_cnt++;
        tick();
        // Executor inputs during DELAY must be ignored.
        jmp_valid = 1'b1; jmp_addr = 5'd0; delay = 5'd7; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (pc !== 5'd12 || instr_valid !== 1'b0 || instr_out !== 16'h0000)
                $display("FAIL jump_delay[%0d] got pc=%0d valid=%0b out=%h exp pc=12 valid=0 out=0000",
                         i, pc, instr_valid, instr_out);
            else pass_cnt++;
            tick();
        end
        jmp_valid = 1'b0; delay = 5'd0; stall = 1'b0;
        #1;
        total_cnt++;
        if (pc !== 5'd12 || instr_valid !== 1'b1 || instr_out !== mem[12])
            $display("FAIL jump_resume got pc=%0d valid=%0b out=%h exp pc=12 valid=1 out=%h",
                     pc, instr_valid, instr_out, mem[12]);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_stall_jump();
        do_restart(5'd7, 5'd20);
        stall = 1'b1; jmp_valid = 1'b1; jmp_addr = 5'd25; delay = 5'd4;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++;
            if (pc !== 5'd7 || instr_valid !== 1'b1)
                $display("FAIL stall_hold[%0d] got pc=%0d valid=%0b exp pc=7 valid=1", i, pc, instr_valid);
            else pass_cnt++;
            tick();
        end
        stall = 1'b0; delay = 5'd0;
        #1;
        tick();
        jmp_valid = 1'b0;
        #1;
        total_cnt++;
        if (pc !== 5'd25 || instr_valid !== 1'b1)
            $display("FAIL stall_jump got pc=%0d valid=%0b exp pc=25 valid=1", pc, instr_valid);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_sm_en_pause();
        do_restart(5'd2, 5'd20);
        delay = 5'd5;
        #1;
        tick();
        delay = 5'd0;
        for (int i = 0; i < 2; i++) tick();
        sm_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            total_cnt++;
            if (pc !== 5'd3 || instr_valid !== 1'b0)
                $display("FAIL pause_freeze[%0d] got pc=%0d valid=%0b exp pc=3 valid=0", i, pc, instr_valid);
            else pass_cnt++;
            tick();
        end
        sm_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++;
            if (instr_valid !== 1'b0)
                $display("FAIL pause_remaining[%0d] got valid=%0b exp valid=0", i, instr_valid);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++;
        if (pc !== 5'd3 || instr_valid !== 1'b1)
            $display("FAIL pause_resume got pc=%0d valid=%0b exp pc=3 valid=1", pc, instr_valid);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_restart();
        do_restart(5'd10, 5'd20);
        delay = 5'd6;
        #1;
        tick();
        delay = 5'd0;
        tick();
        tick();
        wrap_bottom = 5'd4; restart = 1'b1;
        #1;
        tick();
        restart = 1'b0;
        #1;
        total_cnt++;
        if (pc !== 5'd4 || instr_valid !== 1'b1 || instr_out !== mem[4])
            $display("FAIL restart_delay got pc=%0d valid=%0b out=%h exp pc=4 valid=1 out=%h",
                     pc, instr_valid, instr_out, mem[4]);
        else pass_cnt++;
        sm_en = 1'b0; wrap_bottom = 5'd17; restart = 1'b1;
        #1;
        tick();
        restart = 1'b0;
        tick();
        #1;
        total_cnt++;
        if (pc !== 5'd17 || instr_valid !== 1'b0)
            $display("FAIL restart_paused got pc=%0d valid=%0b exp pc=17 valid=0", pc, instr_valid);
        else pass_cnt++;
        sm_en = 1'b1;
        #1;
        total_cnt++;
        if (pc !== 5'd17 || instr_valid !== 1'b1)
            $display("FAIL restart_unpause got pc=%0d valid=%0b exp pc=17 valid=1", pc, instr_valid);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_rst_mid_stall();
        do_restart(5'd9, 5'd20);
        stall = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (pc !== 5'd0 || instr_valid !== 1'b0 || instr_out !== 16'h0000)
            $display("FAIL rst_abort got pc=%0d valid=%0b out=%h exp pc=0 valid=0 out=0000",
                     pc, instr_valid, instr_out);
        else pass_cnt++;
        tick();
        rst_n = 1'b1; stall = 1'b0;
        #1;
        total_cnt++;
        if (pc !== 5'd0 || instr_valid !== 1'b0)
            $display("FAIL rst_idle got pc=%0d valid=%0b exp pc=0 valid=0", pc, instr_valid);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (pc !== 5'd0 || instr_valid !== 1'b1)
            $display("FAIL rst_exec got pc=%0d valid=%0b exp pc=0 valid=1", pc, instr_valid);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (pc !== 5'd1)
            $display("FAIL rst_advance got pc=%0d exp pc=1", pc);
        else pass_cnt++;
        tick();
    endtask

    // Reference model: pc, cycles still owed to a delay, and whether running.
    task automatic test_random();
        int  m_pc;
        int  m_wait;
        bit  m_run;
        bit  exp_valid;
        logic [15:0] exp_out;
        int  r;
        do_restart(5'($urandom), 5'($urandom));
        m_pc = int'(wrap_bottom); m_wait = 0; m_run = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            restart   = ($urandom_range(0, 49) == 0);
            sm_en     = ($urandom_range(0, 9) != 0);
            stall     = ($urandom_range(0, 3) == 0);
            jmp_valid = ($urandom_range(0, 4) == 0);
            jmp_addr  = 5'($urandom);
            r = int'($urandom_range(0, 9));
            if (r < 7)      delay = 5'd0;
            else if (r < 9) delay = 5'($urandom_range(1, 4));
            else            delay = 5'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                wrap_bottom = 5'($urandom);
                wrap_top    = 5'($urandom);
            end
            #1;
            exp_valid = m_run && (m_wait == 0) && sm_en;
            exp_out   = exp_valid ? mem[m_pc] : 16'h0000;
            total_cnt++;
            if (pc !== 5'(m_pc) || read_addr !== 5'(m_pc))
                $display("FAIL rand_pc cyc=%0d got pc=%0d addr=%0d exp=%0d", cyc, pc, read_addr, m_pc);
            else pass_cnt++;
            total_cnt++;
            if (instr_valid !== exp_valid)
                $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", cyc, instr_valid, exp_valid);
            else pass_cnt++;
            total_cnt++;
            if (instr_out !== exp_out)
                $display("FAIL rand_out cyc=%0d got=%h exp=%h", cyc, instr_out, exp_out);
            else pass_cnt++;
            if (restart) begin
                m_pc = int'(wrap_bottom); m_wait = 0; m_run = 1'b1;
            end else if (sm_en) begin
                if (!m_run) m_run = 1'b1;
                else if (m_wait > 0) m_wait = m_wait - 1;
                else if (!stall) begin
                    if (jmp_valid)                   m_pc = int'(jmp_addr);
                    else if (m_pc == int'(wrap_top)) m_pc = int'(wrap_bottom);
                    else                             m_pc = (m_pc + 1) % 32;
                    m_wait = int'(delay);
                end
            end
            tick();
        end
        restart = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'((i * 16'h0101) ^ 16'hA5C3) ^ 16'($urandom_range(0, 255) << 8);
        test_reset();
        test_wrap_basic();
        test_modulo_wrap();
        test_jump_delay();
        test_stall_jump();
        test_sm_en_pause();
        test_restart();
        test_rst_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
